vga_sync_gen: RTL and testbench

- Consumes the one-cycle pixel strobe (25 MHz rate) produced by the clock-divider stage.
- Generates 640x480@60 VGA horizontal/vertical timing: hsync, vsync, video_on, current pixel coordinates and a frame-start pulse.
- Feeds the drum-lane renderer and the VGA output pins.
- Runs entirely on the 50 MHz system clock; the 25 MHz rate is used only as an enable.

---
 rtl/vga_timing_pkg.sv | 53 +++++
 rtl/vga_sync_gen_if.sv | 64 ++++++
 rtl/vga_axis_counter.sv | 39 +++
 rtl/vga_sync_gen.sv | 131 +++++++++++++
 tb/tb_vga_sync_gen.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
//   Shared 640x480@60 timing constants, derived totals, sync pulse window
//   positions, the coordinate width and the 3-3-2 colour type. The helper
//   function builds the optional colour-bar test pattern.
//
//   Optional feature macro: VGA_TEST_PATTERN_EN. It enables the rgb port on
//   the sync generator. test_pattern() is only used when that macro is defined.
// -----------------------------------------------------------------------------
package vga_timing_pkg;

   // Coordinate/counter width. Both totals below must fit in 2**CNT_W.
   localparam int CNT_W = 10;

   // Horizontal timing, in pixels
   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_H_TOTAL  = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;

   // Vertical timing, in lines
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;
   localparam int VGA_V_TOTAL  = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

   // Sync windows: start is inclusive, end is exclusive
   localparam int VGA_H_SYNC_START = VGA_H_ACTIVE + VGA_H_FP;
   localparam int VGA_H_SYNC_END   = VGA_H_SYNC_START + VGA_H_SYNC;
   localparam int VGA_V_SYNC_START = VGA_V_ACTIVE + VGA_V_FP;
   localparam int VGA_V_SYNC_END   = VGA_V_SYNC_START + VGA_V_SYNC;

   // 3-3-2 colour, packed MSB first as {r, g, b}
   typedef struct packed {
      logic [2:0] r;
      logic [2:0] g;
      logic [1:0] b;
   } rgb332_t;

   // Colour bars: coarse column bits drive red, coarse line bits drive green,
   // and the top coordinate bits pick the blue component.
   function automatic rgb332_t test_pattern(input logic [CNT_W-1:0] x,
                                            input logic [CNT_W-1:0] y);
      rgb332_t c;
      c.r = x[8:6];
      c.g = y[8:6];
      c.b = {x[9], y[9]};
      return c;
   endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// -----------------------------------------------------------------------------
// vga_sync_gen_if
//   Bundles the pixel strobe and the registered timing outputs of the VGA sync
//   generator.
//
//   Signals:
//     pix_tick    one-clk pixel strobe (driven by the divider side)
//     hsync       horizontal sync, active-low
//     vsync       vertical sync, active-low
//     video_on    presented pixel lies in the visible area
//     pixel_x     column of the presented pixel
//     pixel_y     line of the presented pixel
//     frame_tick  one-clk pulse when pixel (0,0) is presented
//     rgb         3-3-2 test pattern (only with VGA_TEST_PATTERN_EN)
//
//   Modports:
//     master  the sync generator (consumes pix_tick, drives the timing outputs)
//     slave   a consumer such as the renderer / pin driver
//
//   Handshake: there is no back-pressure. A pixel is presented on the clk
//   edge where pix_tick is high; the outputs then hold until the next such
//   edge, except frame_tick which is high for exactly one clk.
// -----------------------------------------------------------------------------
interface vga_sync_gen_if;
   import vga_timing_pkg::*;

   logic             pix_tick;
   logic             hsync;
   logic             vsync;
   logic             video_on;
   logic [CNT_W-1:0] pixel_x;
   logic [CNT_W-1:0] pixel_y;
   logic             frame_tick;
`ifdef VGA_TEST_PATTERN_EN
   rgb332_t          rgb;
`endif

   modport master (
      input  pix_tick,
      output hsync,
      output vsync,
      output video_on,
      output pixel_x,
      output pixel_y,
`ifdef VGA_TEST_PATTERN_EN
      output rgb,
`endif
      output frame_tick
   );

   modport slave (
      output pix_tick,
      input  hsync,
      input  vsync,
      input  video_on,
      input  pixel_x,
      input  pixel_y,
`ifdef VGA_TEST_PATTERN_EN
      input  rgb,
`endif
      input  frame_tick
   );

endinterface

// File: rtl/vga_axis_counter.sv
// -----------------------------------------------------------------------------
// vga_axis_counter
//   One timing axis: counts 0..MAX_VAL while enabled, then wraps to 0.
//
//   Ports:
//     clk    system clock
//     rst_n  synchronous active-low reset (count -> 0)
//     en     advance by one on this clk edge
//     count  current position on the axis
//     wrap   combinational: count is at MAX_VAL, so the next enabled edge
//            returns it to 0
// -----------------------------------------------------------------------------
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int MAX_VAL = VGA_H_TOTAL - 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [CNT_W-1:0] count,
   output logic             wrap
);

   assign wrap = (count == CNT_W'(MAX_VAL));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= '0;
      end else if (en) begin
         if (wrap) begin
            count <= '0;
         end else begin
            count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//   640x480@60 VGA timing generator running on the 50 MHz system clock, with
//   the 25 MHz pixel strobe used only as an enable.
//
//   Ports:
//     clk    50 MHz system clock
//     rst_n  synchronous active-low reset, wins over pix_tick
//     bus    vga_sync_gen_if.master: pix_tick in; hsync, vsync, video_on,
//            pixel_x, pixel_y, frame_tick (and rgb) out
//
//   Optional feature macro: VGA_TEST_PATTERN_EN adds a registered 3-3-2
//   colour-bar pattern on bus.rgb. Without it the rgb port and logic are gone.
//
//   Timing: on every pix_tick edge the outputs are loaded from the counters'
//   value before they advance, so the outputs describe the pixel whose
//   coordinates the counters held at that edge (one pixel of latency).
// -----------------------------------------------------------------------------
module vga_sync_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic           clk,
   input  logic           rst_n,
   vga_sync_gen_if.master bus
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             v_en;

   // Decoded attributes of the pixel the counters currently point at
   logic             vis_now;
   logic             hsync_now;
   logic             vsync_now;

   // High while the counters sit at (0,0). Reset places them there, and a
   // pix_tick with both axes wrapping moves them back. Tracking this as a flag
   // avoids a full two-axis compare for frame_tick.
   logic             at_origin;

   // ---------------------------------------------------------------------
   // Axis counters: the line counter advances only on the pixel strobe that
   // ends a line.
   // ---------------------------------------------------------------------
   vga_axis_counter #(
      .MAX_VAL (H_TOTAL - 1)
   ) u_h_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (bus.pix_tick),
      .count (h_cnt),
      .wrap  (h_wrap)
   );

   assign v_en = bus.pix_tick & h_wrap;

   vga_axis_counter #(
      .MAX_VAL (V_TOTAL - 1)
   ) u_v_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (v_en),
      .count (v_cnt),
      .wrap  (v_wrap)
   );

   // ---------------------------------------------------------------------
   // Decode from the pre-increment counters
   // ---------------------------------------------------------------------
   always_comb begin
      vis_now   = (h_cnt < CNT_W'(H_ACTIVE)) && (v_cnt < CNT_W'(V_ACTIVE));
      hsync_now = !((h_cnt >= CNT_W'(H_SYNC_START)) && (h_cnt < CNT_W'(H_SYNC_END)));
      vsync_now = !((v_cnt >= CNT_W'(V_SYNC_START)) && (v_cnt < CNT_W'(V_SYNC_END)));
   end

   // ---------------------------------------------------------------------
   // Output registers: load on pix_tick, hold otherwise. frame_tick is a
   // single-clk pulse, so it clears on every non-strobe edge.
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         at_origin      <= 1'b1;
         bus.hsync      <= 1'b1;
         bus.vsync      <= 1'b1;
         bus.video_on   <= 1'b0;
         bus.pixel_x    <= '0;
         bus.pixel_y    <= '0;
         bus.frame_tick <= 1'b0;
      end else if (bus.pix_tick) begin
         at_origin      <= h_wrap & v_wrap;
         bus.hsync      <= hsync_now;
         bus.vsync      <= vsync_now;
         bus.video_on   <= vis_now;
         bus.pixel_x    <= h_cnt;
         bus.pixel_y    <= v_cnt;
         bus.frame_tick <= at_origin;
      end else begin
         bus.frame_tick <= 1'b0;
      end
   end

`ifdef VGA_TEST_PATTERN_EN
   // Colour pattern, blanked to black outside the visible area
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         bus.rgb <= '0;
      end else if (bus.pix_tick) begin
         bus.rgb <= vis_now ? test_pattern(h_cnt, v_cnt) : '0;
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//   Scoreboard bench for vga_sync_gen. Horizontal timing is the standard
//   800-pixel line; the vertical axis is shortened (20 active, 3 FP, 2 sync,
//   4 BP -> 29 lines) so that whole frames, the vsync window and the frame
//   spacing fit in a short run. The vsync window is therefore lines 23..24.
//
//   The driver pushes the expected presented pixel when it raises pix_tick.
//   A monitor, on every falling edge, checks: reset values after a reset
//   edge, the popped expectation after a strobe edge, or the held values with
//   frame_tick low after an idle edge. Hand-picked pixels get extra named
//   checks against literal values.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

   localparam int VT          = 29;
   localparam int VA          = 20;
   localparam int VSS         = 23;
   localparam int VSE         = 25;
   localparam int FRAME_TICKS = 800 * VT;

   // Layout: {hsync, vsync, video_on, pixel_x[9:0], pixel_y[9:0], frame_tick, rgb[7:0]}
   localparam logic [31:0] RST_VEC = {1'b1, 1'b1, 1'b0, 10'd0, 10'd0, 1'b0, 8'h00};

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   vga_sync_gen_if bus ();

   vga_sync_gen #(
      .V_ACTIVE (20),
      .V_FP     (3),
      .V_SYNC   (2),
      .V_BP     (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // ---------------- clock ----------------
   always #10 clk = ~clk;

   // ---------------- scoreboard state ----------------
   logic [31:0] exp_q[$];
   int          checks   = 0;
   int          failures = 0;
   int          mx       = 0;
   int          my       = 0;

   logic [7:0]  act_rgb;
   logic [31:0] act;

`ifdef VGA_TEST_PATTERN_EN
   assign act_rgb = bus.rgb;
`else
   assign act_rgb = 8'h00;
`endif
   assign act = {bus.hsync, bus.vsync, bus.video_on, bus.pixel_x, bus.pixel_y,
                 bus.frame_tick, act_rgb};

   task automatic check(input string nm, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, want, $time);
      end
   endtask

   task automatic hand(input string nm, input logic got, input logic want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s: got %b expected %b (t=%0t)", nm, got, want, $time);
      end
   endtask

   // ---------------- reference model ----------------
   task automatic model_push();
      logic       hs, vs, vo, ft;
      logic [7:0] c;
      logic [9:0] xv, yv;
      xv = mx[9:0];
      yv = my[9:0];
      vo = (mx < 640) && (my < VA);
      hs = !((mx >= 656) && (mx < 752));
      vs = !((my >= VSS) && (my < VSE));
      ft = (mx == 0) && (my == 0);
      c  = 8'h00;
`ifdef VGA_TEST_PATTERN_EN
      if (vo) c = {xv[8:6], yv[8:6], xv[9], yv[9]};
`endif
      exp_q.push_back({hs, vs, vo, xv, yv, ft, c});
      mx++;
      if (mx == 800) begin
         mx = 0;
         my++;
         if (my == VT) my = 0;
      end
   endtask

   // ---------------- driver ----------------
   // Called at a falling edge: strobe for one clk, then idle for gap clks.
   task automatic tick(input int gap);
      bus.pix_tick = 1'b1;
      model_push();
      @(negedge clk);
      bus.pix_tick = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // ---------------- monitor ----------------
   logic        ev_valid = 1'b0;
   logic        ev_rst   = 1'b0;
   logic        ev_tick  = 1'b0;
   logic [31:0] held     = RST_VEC;
   int          ft_cnt   = 0;
   bit          have_ft  = 0;

   always @(posedge clk) begin
      ev_valid <= 1'b1;
      ev_rst   <= !rst_n;
      ev_tick  <= bus.pix_tick;
   end

   task automatic directed(input int x, input int y);
      if (x == 0   && y == 0) begin
         hand("origin_frame_tick", act[8], 1'b1);
         hand("origin_video_on", act[29], 1'b1);
      end
      if (x == 639 && y == 0)  hand("video_on_col639", act[29], 1'b1);
      if (x == 640 && y == 0)  hand("video_on_col640", act[29], 1'b0);
      if (x == 655 && y == 0)  hand("hsync_col655", act[31], 1'b1);
      if (x == 656 && y == 0)  hand("hsync_col656", act[31], 1'b0);
      if (x == 751 && y == 0)  hand("hsync_col751", act[31], 1'b0);
      if (x == 752 && y == 0)  hand("hsync_col752", act[31], 1'b1);
      if (x == 0   && y == 1)  check("line_wrap_xy", {12'd0, act[28:9]}, {12'd0, 10'd0, 10'd1});
      if (x == 0   && y == 19) hand("video_on_line19", act[29], 1'b1);
      if (x == 0   && y == 20) hand("video_on_line20", act[29], 1'b0);
      if (x == 799 && y == 22) hand("vsync_line22", act[30], 1'b1);
      if (x == 0   && y == 23) hand("vsync_line23", act[30], 1'b0);
      if (x == 799 && y == 24) hand("vsync_line24", act[30], 1'b0);
      if (x == 0   && y == 25) hand("vsync_line25", act[30], 1'b1);
`ifdef VGA_TEST_PATTERN_EN
      if (x == 100 && y == 10) check("rgb_100_10", {24'd0, act[7:0]}, {24'd0, 8'h20});
      if (x == 700 && y == 10) check("rgb_700_10", {24'd0, act[7:0]}, {24'd0, 8'h00});
`endif
   endtask

   always @(negedge clk) begin
      logic [31:0] e;
      if (ev_valid) begin
         if (ev_rst) begin
            check("reset_values", act, RST_VEC);
            held    = RST_VEC;
            ft_cnt  = 0;
            have_ft = 0;
         end else if (ev_tick) begin
            if (exp_q.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL scoreboard_underflow: got strobe with no expectation (t=%0t)", $time);
            end else begin
               e = exp_q.pop_front();
               check($sformatf("pixel_%0d_%0d", e[28:19], e[18:9]), act, e);
               held = e;
               directed(int'(e[28:19]), int'(e[18:9]));
               ft_cnt++;
               if (act[8] === 1'b1) begin
                  if (have_ft) check("frame_spacing", ft_cnt, FRAME_TICKS);
                  have_ft = 1;
                  ft_cnt  = 0;
               end
            end
         end else begin
            e    = held;
            e[8] = 1'b0;
            check("hold_idle", act, e);
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      bus.pix_tick = 1'b0;
      rst_n        = 1'b0;
      // Reset held for 5 clks while the strobe toggles
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         bus.pix_tick = i[0];
      end
      @(negedge clk);
      rst_n        = 1'b1;
      bus.pix_tick = 1'b0;
      repeat (2) @(negedge clk);

      // Line 0: strobe every other clk
      for (int i = 0; i < 800; i++) tick(1);
      // Line 1: mixed gaps (0, 1, 2 idle clks)
      for (int i = 0; i < 800; i++) tick(i % 3);
      // Rest of frame 0, all of frame 1, then up to pixel (300,12) of frame 2
      for (int i = 0; i < FRAME_TICKS - 1600; i++) tick(0);
      for (int i = 0; i < FRAME_TICKS + 12 * 800 + 301; i++) tick(0);

      // Mid-frame reset for one edge, with the strobe high to show reset wins
      rst_n        = 1'b0;
      bus.pix_tick = 1'b1;
      mx           = 0;
      my           = 0;
      @(negedge clk);
      rst_n        = 1'b1;
      bus.pix_tick = 1'b0;
      repeat (2) @(negedge clk);
      for (int i = 0; i < 3; i++) tick(1);
      repeat (4) @(negedge clk);

      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
